rpsc_fault_annunciator: RTL
===========================

Name: rpsc_fault_annunciator

Overview:
- Sequences the eight RPSC fault channels, FF1..FF8, on one card.
- Synchronizes and debounces each fault input, then latches it.
- Runs each channel through an alarm/acknowledge/clear sequence and drives flashing or steady lamps.
- Captures the first-out fault, honours lamp test, and generates the Emergency and PAMP interlock outputs from latched state.

Parameters:
- N_CH, 8, number of fault channels.
- DEBOUNCE_CYC, 16, consecutive stable cycles required before the filtered level changes (legal range 1..255).
- FLASH_HALF, 8, cycles per half-period of the lamp flash (legal range 1..65535).
- EMERG_MASK, 8'h01, channels whose latched fault drives emergency (default FF1).
- INTLK_MASK, 8'h7E, channels whose latched fault drives pamp_interlock (default FF2..FF7).

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- fault_in, in, N_CH: raw fault levels, asynchronous to clk; 1 = fault.
- ack, in, 1: operator acknowledge; synchronous to clk, active-high, sampled every cycle.
- clr, in, 1: operator clear request; synchronous to clk, active-high.
- lamp_test, in, 1: asynchronous level that forces all lamps on.
- fault_latched, out, N_CH: 1 while the channel is in ALARM or ACKED.
- lamp, out, N_CH: lamp drive per channel.
- first_out, out, N_CH: one-hot (or zero) marker of the first fault of the current episode.
- emergency, out, 1: OR of fault_latched & EMERG_MASK.
- pamp_interlock, out, 1: OR of fault_latched & INTLK_MASK.

Behaviour:
- Reset (asynchronous, active-high) clears all of the following, whenever reset is asserted, including mid-sequence:
  - sync flops, debounce counters and the filtered/prev registers;
  - every channel state to NORMAL;
  - first_out, flash counter and flash phase;
  - all outputs, which read 0 during reset.
- Input conditioning:
  - fault_in and lamp_test each pass through a 2-flop synchronizer.
  - Per-channel debounce counter: increments while sync != filtered and resets to 0 when they are equal.
  - When the count reaches DEBOUNCE_CYC, filtered takes the sync value and the counter returns to 0.
  - A pulse shorter than DEBOUNCE_CYC cycles is never seen downstream.
- Per-channel rise = filtered & ~prev, where prev is filtered delayed by one cycle.
- Per-channel FSM states: NORMAL, ALARM, ACKED.
  - NORMAL -> ALARM on rise.
  - ALARM -> ACKED on ack. clr has no effect in ALARM.
  - ACKED -> NORMAL on clr when filtered = 0. clr while filtered = 1 is ignored and the state holds.
  - ACKED -> ALARM on rise, i.e. the fault cleared and returned before clr (re-alarm).
  - ack and clr in the same cycle: each channel acts on its own state as above, so an ALARM channel goes to ACKED and is not cleared in that cycle.
  - rise and ack in the same cycle on a NORMAL channel: the channel enters ALARM; the ack is not applied to it.
- First-out:
  - Captured when every channel was NORMAL in the previous cycle and at least one channel enters ALARM.
  - Simultaneous entries resolve to the lowest index.
  - Holds through ack, re-alarms and later faults.
  - Zeroed when all channels are NORMAL.
- Flash:
  - Free-running counter wraps at FLASH_HALF-1 and toggles the phase on wrap.
  - Phase is 1 for the first FLASH_HALF cycles after reset.
- Lamp per channel:
  - Lamp = phase in ALARM, 1 in ACKED, 0 in NORMAL.
  - When the synchronized lamp_test is 1, all lamps are 1.
  - lamp_test affects lamp only; it never alters state, first_out, emergency or pamp_interlock.
- Outputs:
  - All outputs are registered, decoded from state the cycle after the state update.
  - Latency from fault_in change to fault_latched/emergency/pamp_interlock: DEBOUNCE_CYC+4 clk edges (2 sync, DEBOUNCE_CYC debounce, 1 FSM, 1 output register).
  - ack or clr to output change: 2 edges.
  - lamp_test to lamp change: 3 edges.

Test Plan (DEBOUNCE_CYC=4, FLASH_HALF=4, default masks):
- fault_in[0] 0->1 held -> fault_latched=8'h01, first_out=8'h01 and emergency=1 exactly 8 edges later; lamp[0] toggles every 4 cycles; pamp_interlock=0.
- fault_in[3] 3-cycle glitch -> no change on any output. A 4-cycle hold latches channel 3 and sets pamp_interlock=1.
- Channels 5 and 2 rise on the same cycle from all-NORMAL -> first_out=8'h04. ack -> lamp=8'h24 steady. clr with faults still present -> no change. Drop both faults, wait 8 cycles, clr -> all outputs 0 and first_out=0.
- Channel 6 acked, fault drops, then returns before clr -> channel 6 back in ALARM and flashing; first_out unchanged.
- ack and clr in the same cycle with channel 1 in ALARM and channel 4 in ACKED with filtered=0 -> channel 1 goes to ACKED, channel 4 goes to NORMAL.
- lamp_test=1 with no faults -> lamp=8'hFF after 3 edges and fault_latched=0. Assert reset mid-ALARM -> all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/rpsc_fault_annunciator.sv
`default_nettype none
// ============================================================================
// rpsc_fault_annunciator : eight-channel RPSC fault annunciator (debounce,
//   alarm/ack/clear sequencing, first-out, flashing lamps, interlocks)
// Revision: 1.0
// ============================================================================
module rpsc_fault_annunciator #(
    parameter int              N_CH         = 8,
    parameter int              DEBOUNCE_CYC = 16,
    parameter int              FLASH_HALF   = 8,
    parameter logic [N_CH-1:0] EMERG_MASK   = N_CH'(8'h01),
    parameter logic [N_CH-1:0] INTLK_MASK   = N_CH'(8'h7E)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] fault_in,
    input  logic            ack,
    input  logic            clr,
    input  logic            lamp_test,
    output logic [N_CH-1:0] fault_latched,
    output logic [N_CH-1:0] lamp,
    output logic [N_CH-1:0] first_out,
    output logic            emergency,
    output logic            pamp_interlock
);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_ALARM  = 2'd1,
        ST_ACKED  = 2'd2
    } state_t;

    localparam logic [7:0]  c_db_last = 8'(DEBOUNCE_CYC - 1);
    localparam logic [15:0] c_fh_last = 16'(FLASH_HALF - 1);

    logic [N_CH-1:0] r_fault_s1, r_fault_s2, r_prev;
    logic            r_lt_s1, r_lt_s2;
    logic [N_CH-1:0] w_filt, w_rise;
    logic [N_CH-1:0] w_alarm, w_acked, w_nxt_alarm, w_nxt_normal;
    logic [N_CH-1:0] w_latched, w_pick;
    logic [N_CH-1:0] r_first;
    logic [15:0]     r_flash_cnt;
    logic            r_phase;
    logic            w_all_normal, w_all_normal_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fault_s1 <= '0;
            r_fault_s2 <= '0;
            r_lt_s1    <= 1'b0;
            r_lt_s2    <= 1'b0;
            r_prev     <= '0;
        end else begin
            r_fault_s1 <= fault_in;
            r_fault_s2 <= r_fault_s1;
            r_lt_s1    <= lamp_test;
            r_lt_s2    <= r_lt_s1;
            r_prev     <= w_filt;
        end
    end

    assign w_rise = w_filt & ~r_prev;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [7:0] r_db_cnt;
        logic       r_filt;
        state_t     r_state, w_state_nxt;

        // Filtered level only moves after DEBOUNCE_CYC consecutive disagreeing samples
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_db_cnt <= '0;
                r_filt   <= 1'b0;
            end else if (r_fault_s2[gi] == r_filt) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_db_last) begin
                r_db_cnt <= '0;
                r_filt   <= r_fault_s2[gi];
            end else begin
                r_db_cnt <= r_db_cnt + 8'd1;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) r_state <= ST_NORMAL;
            else       r_state <= w_state_nxt;
        end

        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                ST_NORMAL: if (w_rise[gi]) w_state_nxt = ST_ALARM;
                ST_ALARM:  if (ack)        w_state_nxt = ST_ACKED;
                ST_ACKED: begin
                    if (w_rise[gi])             w_state_nxt = ST_ALARM;
                    else if (clr && !r_filt)    w_state_nxt = ST_NORMAL;
                end
                default:                        w_state_nxt = ST_NORMAL;
            endcase
        end

        assign w_filt[gi]       = r_filt;
        assign w_alarm[gi]      = (r_state == ST_ALARM);
        assign w_acked[gi]      = (r_state == ST_ACKED);
        assign w_nxt_alarm[gi]  = (w_state_nxt == ST_ALARM);
        assign w_nxt_normal[gi] = (w_state_nxt == ST_NORMAL);
    end

    assign w_latched        = w_alarm | w_acked;
    assign w_all_normal     = ~|w_latched;
    assign w_all_normal_nxt = &w_nxt_normal;
    // Isolate the lowest set bit so simultaneous first faults favour the lowest index
    assign w_pick           = w_nxt_alarm & (~w_nxt_alarm + N_CH'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_first <= '0;
        end else if (w_all_normal_nxt) begin
            r_first <= '0;
        end else if (w_all_normal && (|w_nxt_alarm)) begin
            r_first <= w_pick;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flash_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (r_flash_cnt == c_fh_last) begin
            r_flash_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_flash_cnt <= r_flash_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_latched  <= '0;
            lamp           <= '0;
            first_out      <= '0;
            emergency      <= 1'b0;
            pamp_interlock <= 1'b0;
        end else begin
            fault_latched  <= w_latched;
            lamp           <= r_lt_s2 ? '1 : (w_acked | (w_alarm & {N_CH{r_phase}}));
            first_out      <= r_first;
            emergency      <= |(w_latched & EMERG_MASK);
            pamp_interlock <= |(w_latched & INTLK_MASK);
        end
    end

endmodule
`default_nettype wire
